// File: rtl/aud_wr_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : aud_axil_defs (package)
// Desc     : Shared widths, write-response codes and arbiter state encoding
//            for the audio controller AXI4-Lite write arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package aud_axil_defs;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 7;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2,
        ST_FWD  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/aud_wr_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : aud_wr_arbiter_if
// Desc     : AXI4-Lite write channel (AW, W, B). The master modport drives
//            address/data valid and BREADY; the slave modport answers.
// Revision : 1.0 - initial release
//==============================================================================
interface aud_wr_arbiter_if #(
    parameter int ADDR_W = aud_axil_defs::ADDR_W,
    parameter int DATA_W = aud_axil_defs::DATA_W
);
    logic              AWVALID;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWREADY;
    logic              WVALID;
    logic [DATA_W-1:0] WDATA;
    logic              WREADY;
    logic              BVALID;
    logic [1:0]        BRESP;
    logic              BREADY;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface
`default_nettype wire

// File: rtl/aud_wr_arbiter_rr_pick2.sv
`default_nettype none
//==============================================================================
// Module   : rr_pick2
// Desc     : Combinational two-way round-robin picker. When both request,
//            the one that was not served last wins.
// Revision : 1.0 - initial release
//==============================================================================
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_valid
);
    // Pick the requester index; contention alternates away from i_last
    always_comb begin
        o_valid = |i_req;
        o_gnt   = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt = ~i_last;
        end else if (i_req[1]) begin
            o_gnt = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/aud_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : aud_wr_arbiter
// Desc     : Round-robin arbiter giving two requesters (boot config
//            sequencer, runtime volume/tone updater) a shared AXI4-Lite
//            write channel. Each grant owns one complete AW/W/B transaction;
//            a watchdog aborts a hung transfer with SLVERR.
// Revision : 1.0 - initial release
//==============================================================================
module aud_wr_arbiter #(
    parameter int ADDR_W  = aud_axil_defs::ADDR_W,
    parameter int DATA_W  = aud_axil_defs::DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             ARESETn,
    aud_wr_arbiter_if.slave  s0,
    aud_wr_arbiter_if.slave  s1,
    aud_wr_arbiter_if.master m,
    output logic             busy,
    output logic             timeout_err
);
    import aud_axil_defs::*;

    localparam logic [7:0] c_wd_limit = 8'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic [1:0]        r_bresp;
    logic [7:0]        r_wd_cnt;

    logic [1:0]        w_req;
    logic              w_pick;
    logic              w_pick_vld;
    logic              w_grant;
    logic              w_wd_expire;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_fwd_ack;
    logic              w_enter_wd;

    // A requester only counts when address and data are both offered
    assign w_req = {s1.AWVALID & s1.WVALID, s0.AWVALID & s0.WVALID};

    rr_pick2 u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_gnt   (w_pick),
        .o_valid (w_pick_vld)
    );

    assign w_grant     = (r_state == ST_IDLE) && w_pick_vld;
    assign w_wd_expire = ((r_state == ST_XFER) || (r_state == ST_RESP)) &&
                         (r_wd_cnt == c_wd_limit);
    // A channel is done once its valid has already dropped or handshakes now
    assign w_aw_done   = ~r_awvalid | m.AWREADY;
    assign w_w_done    = ~r_wvalid  | m.WREADY;
    assign w_fwd_ack   = (r_state == ST_FWD) && (r_gnt ? s1.BREADY : s0.BREADY);
    assign w_enter_wd  = (w_state_nxt != r_state) &&
                         ((w_state_nxt == ST_XFER) || (w_state_nxt == ST_RESP));

    // State register
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the watchdog overrides any handshake in XFER/RESP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_wd_expire) begin
                    w_state_nxt = ST_FWD;
                end else if (w_aw_done && w_w_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_wd_expire) begin
                    w_state_nxt = ST_FWD;
                end else if (m.BVALID && r_bready) begin
                    w_state_nxt = ST_FWD;
                end
            end
            ST_FWD: begin
                if (w_fwd_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's address/data and identity at grant time
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_gnt    <= 1'b0;
        end else if (w_grant) begin
            r_awaddr <= w_pick ? s1.AWADDR : s0.AWADDR;
            r_wdata  <= w_pick ? s1.WDATA  : s0.WDATA;
            r_gnt    <= w_pick;
        end
    end

    // AW and W valids rise together at grant and retire independently
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else if (w_grant) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else if (r_state == ST_XFER) begin
            if (w_wd_expire) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
            end else begin
                if (m.AWREADY) r_awvalid <= 1'b0;
                if (m.WREADY)  r_wvalid  <= 1'b0;
            end
        end
    end

    // BREADY covers exactly the RESP state; response code latched on exit
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_bready <= 1'b0;
            r_bresp  <= BRESP_OKAY;
        end else if (w_wd_expire) begin
            r_bready <= 1'b0;
            r_bresp  <= BRESP_SLVERR;
        end else if ((r_state == ST_XFER) && w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
        end else if ((r_state == ST_RESP) && m.BVALID && r_bready) begin
            r_bready <= 1'b0;
            r_bresp  <= m.BRESP;
        end
    end

    // Watchdog: restarts on entry to XFER/RESP, counts while in them
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wd_cnt <= 8'd0;
        end else if (w_enter_wd) begin
            r_wd_cnt <= 8'd0;
        end else if ((r_state == ST_XFER) || (r_state == ST_RESP)) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end else begin
            r_wd_cnt <= 8'd0;
        end
    end

    // Remember who was served once the response has been handed back
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last <= 1'b1;
        end else if (w_fwd_ack) begin
            r_last <= r_gnt;
        end
    end

    assign m.AWVALID  = r_awvalid;
    assign m.AWADDR   = r_awaddr;
    assign m.WVALID   = r_wvalid;
    assign m.WDATA    = r_wdata;
    assign m.BREADY   = r_bready;

    assign s0.AWREADY = w_grant & ~w_pick;
    assign s0.WREADY  = w_grant & ~w_pick;
    assign s1.AWREADY = w_grant &  w_pick;
    assign s1.WREADY  = w_grant &  w_pick;

    assign s0.BVALID  = (r_state == ST_FWD) & ~r_gnt;
    assign s1.BVALID  = (r_state == ST_FWD) &  r_gnt;
    assign s0.BRESP   = s0.BVALID ? r_bresp : BRESP_OKAY;
    assign s1.BRESP   = s1.BVALID ? r_bresp : BRESP_OKAY;

    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = w_wd_expire;

endmodule
`default_nettype wire
